// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, fetches over a req/ack memory handshake,
// latches the word into the IR and advances only when the controller accepts it.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              instr_accept,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [6:0]        opcode,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_fault,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {S_FETCH, S_VALID, S_FAULT} state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_pc, w_pc_next;
   logic [31:0]       r_ir, w_ir_next;
   logic              r_valid, w_valid_next;
   logic              r_fault, w_fault_next;
   logic              r_flush, w_flush_next;
   logic [CNT_W-1:0]  r_count, w_count_next;
   // Keeps the request low until the first clock after reset release.
   logic              r_run;

   logic w_req;
   logic w_misaligned;

   assign w_req        = (r_state == S_FETCH) && r_run;
   assign w_misaligned = redirect && (redirect_pc[1:0] != 2'b00);

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_ir;
   assign opcode      = r_ir[6:0];
   assign pc          = r_pc;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ir_next    = r_ir;
      w_valid_next = r_valid;
      w_fault_next = r_fault;
      w_flush_next = r_flush;
      w_count_next = r_count;
      case (r_state)
         S_FETCH: begin
            if (w_req) begin
               if (w_misaligned) begin
                  w_fault_next = 1'b1;
                  w_valid_next = 1'b0;
                  w_state_next = S_FAULT;
               end else if (imem_ack) begin
                  // A redirect or pending flush discards the returning word.
                  if (redirect) begin
                     w_pc_next    = redirect_pc;
                     w_flush_next = 1'b0;
                  end else if (r_flush) begin
                     w_flush_next = 1'b0;
                  end else begin
                     w_ir_next    = imem_rdata;
                     w_valid_next = 1'b1;
                     w_count_next = r_count + CNT_W'(1);
                     w_state_next = S_VALID;
                  end
               end else if (redirect) begin
                  w_pc_next    = redirect_pc;
                  w_flush_next = 1'b1;
               end
            end
         end
         S_VALID: begin
            if (instr_accept) begin
               if (w_misaligned) begin
                  w_fault_next = 1'b1;
                  w_valid_next = 1'b0;
                  w_state_next = S_FAULT;
               end else begin
                  w_valid_next = 1'b0;
                  w_pc_next    = redirect ? redirect_pc : r_pc + ADDR_W'(4);
                  w_state_next = S_FETCH;
               end
            end
         end
         S_FAULT: begin
            w_state_next = S_FAULT;
         end
         default: begin
            w_state_next = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_ir    <= NOP_INSTR;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_flush <= 1'b0;
         r_count <= '0;
         r_run   <= 1'b0;
      end else begin
         r_pc    <= w_pc_next;
         r_ir    <= w_ir_next;
         r_valid <= w_valid_next;
         r_fault <= w_fault_next;
         r_flush <= w_flush_next;
         r_count <= w_count_next;
         r_run   <= 1'b1;
      end
   end

endmodule
